// File: rtl/board_updater.sv
// board_updater: per-tick sprite sequencer that owns all writes to the board RAM.
// Visits Pac-Man then the four ghosts. It reads each target tile, commits accepted moves, and tracks score, pellets, contact and win.
module board_updater #(
  parameter int unsigned TICK_CYCLES  = 5_000_000,
  parameter logic [9:0]  PAC_INIT     = 10'd750,
  parameter logic [9:0]  BLINKY_INIT  = 10'd366,
  parameter logic [9:0]  CLYDE_INIT   = 10'd464,
  parameter logic [9:0]  INKY_INIT    = 10'd460,
  parameter logic [9:0]  PINKY_INIT   = 10'd462,
  parameter logic [7:0]  PELLET_TOTAL = 8'd240
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [9:0]  pac_next,
  input  logic [9:0]  blinky_next,
  input  logic [9:0]  clyde_next,
  input  logic [9:0]  inky_next,
  input  logic [9:0]  pinky_next,
  output logic [9:0]  rd_addr,
  input  logic [3:0]  rd_data,
  output logic [9:0]  wr_addr,
  output logic [3:0]  wr_data,
  output logic        wr_en,
  output logic [9:0]  pac_loc,
  output logic [9:0]  blinky_loc,
  output logic [9:0]  clyde_loc,
  output logic [9:0]  inky_loc,
  output logic [9:0]  pinky_loc,
  output logic [15:0] score,
  output logic [7:0]  pellets_left,
  output logic        sweep_done,
  output logic        game_over,
  output logic        win
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT, S_DECIDE, S_ERASE, S_WRITE, S_DONE, S_HALT
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] tick_cnt;
  logic        tick_pending;
  logic [2:0]  idx;
  logic [9:0]  next_sel, next_q;
  logic [3:0]  tile_q;
  logic [9:0]  loc   [5];
  logic [3:0]  under [5];

  logic        pac_turn, last, t_wall, t_pac, t_ghost, reject, contact;
  logic [15:0] score_inc;
  logic [16:0] score_sum;

  assign pac_loc    = loc[0];
  assign blinky_loc = loc[1];
  assign clyde_loc  = loc[2];
  assign inky_loc   = loc[3];
  assign pinky_loc  = loc[4];

  always_comb begin
    case (idx)
      3'd1:    next_sel = blinky_next;
      3'd2:    next_sel = clyde_next;
      3'd3:    next_sel = inky_next;
      3'd4:    next_sel = pinky_next;
      default: next_sel = pac_next;
    endcase
  end

  // Sides: Pac-Man alone vs. the ghosts; same-side targets (including own cell) are blocked.
  always_comb begin
    pac_turn  = (idx == 3'd0);
    last      = (idx == 3'd4);
    t_wall    = (tile_q == 4'd1) || (tile_q >= 4'd9);
    t_pac     = (tile_q == 4'd4);
    t_ghost   = (tile_q >= 4'd5) && (tile_q <= 4'd8);
    reject    = t_wall || (pac_turn ? t_pac : t_ghost);
    contact   = pac_turn ? t_ghost : t_pac;
    score_inc = (tile_q == 4'd2) ? 16'd1 : ((tile_q == 4'd3) ? 16'd10 : 16'd0);
    score_sum = {1'b0, score} + {1'b0, score_inc};
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (tick_pending) state_nxt = S_READ;
      S_READ:   state_nxt = S_WAIT;
      S_WAIT:   state_nxt = S_DECIDE;
      S_DECIDE: begin
        if (reject)       state_nxt = last ? S_DONE : S_READ;
        else if (contact) state_nxt = S_HALT;
        else              state_nxt = S_ERASE;
      end
      S_ERASE:  state_nxt = S_WRITE;
      S_WRITE:  state_nxt = last ? S_DONE : S_READ;
      S_DONE:   state_nxt = (pellets_left == 8'd0) ? S_HALT : S_IDLE;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt     <= '0;
      tick_pending <= 1'b0;
      idx          <= '0;
      next_q       <= '0;
      tile_q       <= '0;
      loc[0]       <= PAC_INIT;
      loc[1]       <= BLINKY_INIT;
      loc[2]       <= CLYDE_INIT;
      loc[3]       <= INKY_INIT;
      loc[4]       <= PINKY_INIT;
      for (int unsigned k = 0; k < 5; k++) under[k] <= '0;
      score        <= '0;
      pellets_left <= PELLET_TOTAL;
      game_over    <= 1'b0;
      win          <= 1'b0;
    end else begin
      // A terminal count in the same cycle as the IDLE pickup must survive, so the set comes last.
      if (state == S_IDLE && tick_pending) tick_pending <= 1'b0;
      if (enable && state != S_HALT) begin
        if (tick_cnt == TICK_CYCLES - 1) begin
          tick_cnt     <= '0;
          tick_pending <= 1'b1;
        end else begin
          tick_cnt <= tick_cnt + 32'd1;
        end
      end
      case (state)
        S_IDLE:   if (tick_pending) idx <= '0;
        S_READ:   next_q <= next_sel;
        S_WAIT:   tile_q <= rd_data;
        S_DECIDE: begin
          if (reject) begin
            if (!last) idx <= idx + 3'd1;
          end else if (contact) begin
            game_over <= 1'b1;
          end
        end
        S_WRITE: begin
          loc[idx] <= next_q;
          if (pac_turn) begin
            under[idx] <= '0;
            score      <= score_sum[16] ? '1 : score_sum[15:0];
            if (score_inc != 16'd0 && pellets_left != 8'd0)
              pellets_left <= pellets_left - 8'd1;
          end else begin
            under[idx] <= tile_q;
          end
          if (!last) idx <= idx + 3'd1;
        end
        S_DONE:   if (pellets_left == 8'd0) win <= 1'b1;
        default:  ;
      endcase
    end
  end

  always_comb begin
    rd_addr    = '0;
    wr_addr    = '0;
    wr_data    = '0;
    wr_en      = 1'b0;
    sweep_done = 1'b0;
    case (state)
      S_READ:  rd_addr = next_sel;
      S_ERASE: begin
        wr_addr = loc[idx];
        wr_data = under[idx];
        wr_en   = 1'b1;
      end
      S_WRITE: begin
        wr_addr = next_q;
        wr_data = {1'b0, idx} + 4'd4;
        wr_en   = 1'b1;
      end
      S_DONE:  sweep_done = 1'b1;
      default: ;
    endcase
  end

endmodule
